// File: rtl/led_rr_arbiter_if.sv
// Request/grant bundle between the requesting client blocks and the round-robin
// arbiter that drives the 2-to-4 LED/select decoder.
interface led_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  // Client side: raises requests, observes ownership.
  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  busy,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/led_rr_arbiter.sv
// Four-way round-robin arbiter for the LED/select decoder; every ownership change
// passes through a one-cycle all-off gap. Define ARB_TIMEOUT_EN to enforce MAX_HOLD.
module led_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic           clk,
  input  logic           reset_n,
  led_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [1:0] winner;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             limit_hit;
`endif

  // First requester found searching upward from last+1; the previous owner sits
  // at offset 4, so it wins only when nobody else is asking.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner = rr_pick(bus.req, last_q);

`ifdef ARB_TIMEOUT_EN
  assign limit_hit = (hold_q == CNT_W'(MAX_HOLD - 1));
`endif

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    last_d    = last_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = '0;
`endif

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        if (|bus.req) begin
          state_d = ST_GRANT;
          idx_d   = winner;
          grant_d = 4'b0001 << winner;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end
      end

      ST_GRANT: begin
        // A voluntary release takes precedence over a limit hit on the same edge.
        if (!bus.req[idx_q]) begin
          state_d = ST_GAP;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          last_d  = idx_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (limit_hit) begin
          state_d   = ST_GAP;
          grant_d   = 4'b0000;
          busy_d    = 1'b0;
          last_d    = idx_q;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from the
  // same pre-edge values; the async reset forces outputs off without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 4'b0000;
      idx_q     <= 2'b00;
      last_q    <= 2'b11;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`endif

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

  // Ownership invariants: at most one grant, busy mirrors it, index agrees.
  a_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant_q));
  a_busy : assert property (@(posedge clk) disable iff (!reset_n)
    busy_q == (grant_q != 4'b0000));
  a_idx : assert property (@(posedge clk) disable iff (!reset_n)
    busy_q |-> grant_q == (4'b0001 << idx_q));
  a_gap : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ST_GAP) |-> (grant_q == 4'b0000));

endmodule

// File: tb/tb_led_rr_arbiter.sv
// Directed bench for led_rr_arbiter; timeout scenarios run when ARB_TIMEOUT_EN
// is defined, the unlimited-hold scenario when it is not.
module tb_led_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  led_rr_arbiter_if bus ();

  led_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                            input logic b, input logic t);
    check($sformatf("%s.grant", tag),     32'(bus.grant),     32'(g));
    check($sformatf("%s.grant_idx", tag), 32'(bus.grant_idx), 32'(i));
    check($sformatf("%s.busy", tag),      32'(bus.busy),      32'(b));
    check($sformatf("%s.timeout", tag),   32'(bus.timeout),   32'(t));
  endtask

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] order_bit;
    reset_n = 1'b0;
    bus.req = 4'b0000;
    #1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    do_reset();

    // Basic grant then release to the other requester.
    bus.req = 4'b0101;
    tick(); expect_out("t1.g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0100;
    tick(); expect_out("t1.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); expect_out("t1.g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick(); expect_out("t1.gap2", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick(); expect_out("t1.idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Full rotation 0,1,2,3,0 with each owner holding 3 cycles.
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      order_bit = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) begin
        tick(); expect_out($sformatf("t2.own%0d.c%0d", k, c), order_bit, 2'(k % 4), 1'b1, 1'b0);
      end
      bus.req = 4'b1111 & ~order_bit;
      tick(); expect_out($sformatf("t2.gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    tick();
    tick();

    // Glitches on non-owner bits do not preempt the owner.
    do_reset();
    bus.req = 4'b0001;
    tick(); expect_out("t3.g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b1011;
    tick(); expect_out("t3.glitch1", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0011;
    tick(); expect_out("t3.glitch2", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0010;
    tick(); expect_out("t3.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); expect_out("t3.g1", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a grant to requester 3.
    do_reset();
    bus.req = 4'b1000;
    tick(); expect_out("t4.g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 expect_out("t4.async", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req = 4'b1001;
    tick();
    reset_n = 1'b1;
    tick(); expect_out("t4.first", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Sole requester is cut every MAX_HOLD cycles and re-granted after the gap.
    do_reset();
    bus.req = 4'b0010;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick(); expect_out($sformatf("t5.r%0d.c%0d", r, c), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      tick(); expect_out($sformatf("t5.to%0d", r), 4'b0000, 2'd1, 1'b0, 1'b1);
    end
    tick(); expect_out("t5.again", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Timeout hands the resource to the other requester.
    do_reset();
    bus.req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick(); expect_out($sformatf("t6.g0.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick(); expect_out("t6.to", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick(); expect_out("t6.g1a", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); expect_out("t6.g1b", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0001;
    tick(); expect_out("t6.gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick(); expect_out("t6.g0back", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Release on the same edge the limit is reached counts as a normal release.
    do_reset();
    bus.req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick(); expect_out($sformatf("t7.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    bus.req = 4'b0000;
    tick(); expect_out("t7.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); expect_out("t7.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    // Without the limit the owner keeps the grant indefinitely.
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 100; c++) begin
      tick();
      check($sformatf("t8.grant.c%0d", c), 32'(bus.grant), 32'h4);
      check($sformatf("t8.timeout.c%0d", c), 32'(bus.timeout), 32'h0);
    end
    bus.req = 4'b0000;
    tick(); expect_out("t8.rel", 4'b0000, 2'd2, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
